oled_serial_receiver: RTL
=========================

// Module: oled_serial_receiver
// PURPOSE
//  AHB-Lite slave that receives the 4-wire OLED serial stream (nCS, DnC, SCLK, SDIN).
//  Deserialises MSB-first bytes, tags each with DnC, buffers them in a small FIFO and
//  exposes them to software for reading.
//  Used for loopback self-test of the OLED transmit path and as a bus-visible display-side model.
//  Serial inputs are synchronous to HCLK; SCLK high and low phases are each >= 1 HCLK cycle.
// PARAMETERS
//  FIFO_DEPTH  4   entries of {dnc, byte[7:0]}; power of two, 2..16
//  CNT_W       3   $clog2(FIFO_DEPTH)+1; width of the STATUS count field
// PORTS
//  HCLK       in   1   system clock
//  HRESET     in   1   reset, asynchronous, active-high
//  HSEL       in   1   AHB slave select
//  HREADY     in   1   AHB bus ready
//  HWRITE     in   1   AHB write
//  HADDR      in   32  address; [3:2] decoded
//  HWDATA     in   32  write data (data phase)
//  HSIZE      in   3   ignored; word access only
//  HTRANS     in   2   transfer type; 2'b00 = no transfer
//  HRDATA     out  32  read data
//  HREADYOUT  out  1   tied 1; zero wait states
//  nCS        in   1   serial chip select, active low
//  DnC        in   1   data(1)/command(0) flag
//  SCLK       in   1   serial clock; sample on rising edge
//  SDIN       in   1   serial data, MSB first
// BEHAVIOUR
//  Map (word offsets):
//   0x0 RXDATA  R: [31]=valid, [8]=dnc, [7:0]=byte; pops the FIFO when non-empty; empty -> 0
//   0x4 STATUS  R: [0]=not_empty [1]=full [2]=overflow [3]=frame_err [4+:CNT_W]=count
//               W: write 1 to [2] or [3] clears that flag
//   0x8 CONTROL R/W: [0]=enable (reset 1); W [1]=1 flushes FIFO (self-clearing, reads 0)
//  AHB: address phase is registered when HREADY&HSEL&HTRANS!=0. Write takes effect at the
//   end of the data phase. HRDATA is combinational from registered control and FIFO head.
//   Pop occurs at the end of the data phase. Other offsets: read 0, write ignored.
//  Front end: nCS/DnC/SCLK/SDIN registered once; rise = SCLK_q & ~SCLK_qq.
//  FSM RX_IDLE/RX_SHIFT:
//   IDLE->SHIFT when nCS_q=0 & enable.
//   SHIFT->IDLE when nCS_q=1 or enable=0.
//   In SHIFT, each rise: shreg<={shreg[6:0],SDIN_q}, bitcnt++.
//   On the 8th rise: push {DnC_q, byte}, bitcnt<=0, stay in SHIFT (multi-byte frames allowed).
//  Latency: a byte is visible in STATUS to an access whose address phase is >= 2 HCLK after
//   the edge that registers the 8th SCLK high.
//  Boundaries:
//   nCS high with 0<bitcnt<8 -> partial byte discarded, frame_err=1 (sticky).
//   enable=0 mid-byte -> partial byte discarded, no error.
//   Push when full and no pop that cycle -> byte dropped, overflow=1 (sticky).
//   Push and pop in the same cycle -> both occur; count unchanged, also when full (no overflow).
//   Flag set and W1C in the same cycle -> set wins.
//   Flush and push in the same cycle -> flush wins; byte lost, no flag.
//   Count wrap: pointers are log2(DEPTH) bits and wrap naturally; count saturates 0..DEPTH.
//  Reset: HRDATA=0, FIFO empty, flags 0, enable=1, FSM IDLE, shreg=0, bitcnt=0.
//   Reset mid-byte abandons it; reception restarts at the next nCS low after release.
// STRUCTURE
//  oled_pkg: HTRANS_IDLE, register offsets, STATUS bit indices, rx_state_t enum.
//  Sub-module byte_fifo #(WIDTH=9, DEPTH): push/pop/flush, full/empty/count, same-cycle
//   push+pop when full accepted.
//  Top holds the AHB decode, CSRs, front end and FSM.
// TESTING
//  1 Reset, read STATUS/CONTROL -> 0x0 / 0x1; RXDATA -> 0x0.
//  2 Send cmd 0x3C (DnC=0), then data 0xA5 (DnC=1), SCLK period 2 HCLK, nCS high between
//    bytes -> STATUS count=2; RXDATA 0x8000_003C then 0x8000_01A5; STATUS=0x0.
//  3 Send 5 bytes 0x01..0x05 (DEPTH 4) -> STATUS=0x47 (count4, full, overflow, not_empty);
//    reads 0x01..0x04; write STATUS 0x4 -> overflow 0.
//  4 nCS high after 3 bits, then full byte 0x81 -> frame_err=1, single entry 0x81.
//  5 FIFO full; RXDATA read coincides with the 8th rise of 0x55 -> no overflow, count stays 4,
//    0x55 last out.
//  6 HRESET asserted after 5 bits of a byte, then enable=0 traffic -> all cleared, nothing
//    captured; enable=1, send 0xF0 -> 0x8000_00F0 (DnC=0).

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED serial receiver: AHB transfer encoding,
// register map offsets, register bit positions and the receive FSM state type.
package oled_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Word offsets, i.e. HADDR[3:2]
  localparam logic [1:0] OFF_RXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CONTROL = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT     = 4;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;

  localparam int RX_VALID_BIT = 31;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with flush. A push into a full FIFO is accepted when a pop
// happens in the same cycle; pointers wrap naturally, count saturates at 0..DEPTH.
module byte_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; empty/count gate every read of stale contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/oled_serial_receiver.sv
// AHB-Lite slave that deserialises the 4-wire OLED stream (nCS, DnC, SCLK, SDIN) into
// DnC-tagged bytes, queues them in a FIFO and exposes RXDATA/STATUS/CONTROL registers.
module oled_serial_receiver
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        nCS,
  input  logic        DnC,
  input  logic        SCLK,
  input  logic        SDIN
);

  // Serial front end
  logic ncs_q, dnc_q, sclk_q, sclk_qq, sdin_q;
  logic sclk_rise;

  // AHB data phase
  logic       dp_valid;
  logic       dp_write;
  logic [1:0] dp_off;
  logic       dp_end;
  logic       rd_rx, wr_status, wr_control;

  // CSRs
  logic enable;
  logic overflow;
  logic frame_err;
  logic flush;
  logic overflow_set;

  // Receive FSM
  rx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic       push_q;
  logic [8:0] push_data;
  logic       frame_err_set;

  // FIFO
  logic [8:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic unused_bits;

  assign HREADYOUT   = 1'b1;
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:4], shreg[7]};

  // NOTE: every flop is written with <= so all state updates see pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ncs_q   <= 1'b1;
      dnc_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      sdin_q  <= 1'b0;
    end else begin
      ncs_q   <= nCS;
      dnc_q   <= DnC;
      sclk_q  <= SCLK;
      sclk_qq <= sclk_q;
      sdin_q  <= SDIN;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;

  // Address phase is captured only while the bus is ready; it then becomes our data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else if (HREADY) begin
      dp_valid <= HSEL & (HTRANS != HTRANS_IDLE);
      dp_write <= HWRITE;
      dp_off   <= HADDR[3:2];
    end
  end

  assign dp_end     = dp_valid & HREADY;
  assign rd_rx      = dp_end & ~dp_write & (dp_off == OFF_RXDATA);
  assign wr_status  = dp_end &  dp_write & (dp_off == OFF_STATUS);
  assign wr_control = dp_end &  dp_write & (dp_off == OFF_CONTROL);
  assign flush      = wr_control & HWDATA[CTRL_FLUSH];

  // A flushed push is simply lost; only a genuinely dropped byte raises overflow.
  assign overflow_set = push_q & fifo_full & ~(rd_rx & ~fifo_empty) & ~flush;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      enable    <= 1'b1;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_control) enable <= HWDATA[CTRL_ENABLE];

      if (overflow_set)                          overflow <= 1'b1;
      else if (wr_status && HWDATA[ST_OVERFLOW]) overflow <= 1'b0;

      if (frame_err_set)                          frame_err <= 1'b1;
      else if (wr_status && HWDATA[ST_FRAME_ERR]) frame_err <= 1'b0;
    end
  end

  // Frames may carry several bytes; bitcnt wraps 7->0 on each completed byte.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state         <= RX_IDLE;
      shreg         <= '0;
      bitcnt        <= '0;
      push_q        <= 1'b0;
      push_data     <= '0;
      frame_err_set <= 1'b0;
    end else begin
      push_q        <= 1'b0;
      frame_err_set <= 1'b0;
      case (state)
        RX_IDLE: begin
          bitcnt <= '0;
          if (!ncs_q && enable) state <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (ncs_q || !enable) begin
            state         <= RX_IDLE;
            bitcnt        <= '0;
            frame_err_set <= ncs_q && enable && (bitcnt != 3'd0);
          end else if (sclk_rise) begin
            shreg  <= {shreg[6:0], sdin_q};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              push_q    <= 1'b1;
              push_data <= {dnc_q, shreg[6:0], sdin_q};
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push_q),
    .pop   (rd_rx),
    .flush (flush),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: default assignment first so no path through the case leaves HRDATA unassigned.
  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_off)
        OFF_RXDATA: begin
          if (!fifo_empty) begin
            HRDATA[RX_VALID_BIT] = 1'b1;
            HRDATA[8:0]          = fifo_dout;
          end
        end
        OFF_STATUS: begin
          HRDATA[ST_NOT_EMPTY]        = ~fifo_empty;
          HRDATA[ST_FULL]             = fifo_full;
          HRDATA[ST_OVERFLOW]         = overflow;
          HRDATA[ST_FRAME_ERR]        = frame_err;
          HRDATA[ST_COUNT +: CNT_W]   = fifo_count;
        end
        OFF_CONTROL: HRDATA[CTRL_ENABLE] = enable;
        default: ;
      endcase
    end
  end

endmodule
